rename_freelist_controller: RTL and testbench
=============================================

Name: rename_freelist_controller

Overview:
Physical-register free-list manager that feeds new physical register names to the 32-entry register renaming table. It hands out up to two physical names per cycle for renaming and drives the table's lock input when names run short. It recycles old physical names released at commit, and rewinds the speculative allocation pointer on restart so it matches the table's rollback point.

Parameters:
PREG_W, 6, physical register name width (64 physical registers)
LIST_DEPTH, 32, free-list entries (physical registers minus architectural registers)
INIT_BASE, 32, first physical name placed in the list at init; logical n is initially mapped to physical n

Ports:
iCLOCK  in  1  clock
inRESET  in  1  reset, asynchronous, active-low
iRESTART_VALID  in  1  pipeline flush; rewind speculative allocations
iALLOC_REQ_0  in  1  rename slot 0 needs a destination register
iALLOC_REQ_1  in  1  rename slot 1 needs a destination register
oALLOC_REGNAME_0  out  PREG_W  physical name offered to slot 0
oALLOC_REGNAME_1  out  PREG_W  physical name offered to slot 1
oLOCK  out  1  to rename table iLOCK; high means no allocation this cycle
iCOMMIT_0_VALID  in  1  committing instruction 0 had a destination
iCOMMIT_0_OLD_REGNAME  in  PREG_W  superseded physical name to free
iCOMMIT_1_VALID  in  1  committing instruction 1 had a destination
iCOMMIT_1_OLD_REGNAME  in  PREG_W  superseded physical name to free
oINIT_DONE  out  1  free list populated
oFREE_COUNT  out  6  speculative free entries (0..32)

Behaviour:
- Storage: LIST_DEPTH x PREG_W circular buffer.
- Pointers: 6-bit head (speculative allocate), chead (committed allocate), tail (free insert); index = ptr[4:0].
- oFREE_COUNT = tail - head, modulo 64.
- Reset: state INIT; head = chead = tail = 0; oINIT_DONE = 0; oLOCK = 1; oFREE_COUNT = 0; regname outputs 0.
- INIT state, 16 cycles:
  - cycle k writes entry 2k = INIT_BASE+2k and entry 2k+1 = INIT_BASE+2k+1.
  - After the last write: tail = 32, state RUN, oINIT_DONE = 1.
  - Requests, commits and restart are ignored during INIT.
- RUN offer (combinational): if both requests are high, slot0 gets list[head] and slot1 gets list[head+1]. If only one request is high, that slot gets list[head].
- oLOCK = (state != RUN) | (oFREE_COUNT < 2) | iRESTART_VALID. The lock is conservative and independent of the request mix, so there is no combinational loop through the requests.
- Allocate: when !oLOCK, head += REQ_0 + REQ_1 at the clock edge. The rename table latches the offered names in the same edge, so allocation has zero-cycle latency.
- Commit, every RUN cycle, including cycles with restart or lock:
  - n = COMMIT_0_VALID + COMMIT_1_VALID.
  - If only COMMIT_0 is valid: list[tail] = OLD_0.
  - If only COMMIT_1 is valid: list[tail] = OLD_1.
  - If both are valid: list[tail] = OLD_0 and list[tail+1] = OLD_1.
  - Then tail += n and chead += n.
  - A freed entry is allocatable from the next cycle; no bypass.
- Restart: head <= chead + n, where n is the commit count of the same cycle. No allocation occurs that cycle.
- Simultaneous allocate and commit: both pointer updates apply. oFREE_COUNT next = count - alloc + n.
- Invariant: tail - chead == 32 in RUN.
- Overflow: freeing into a full list is illegal, since commit never exceeds prior allocation. Simulation assertion: oFREE_COUNT + n <= 32.
- Pointer wrap at 64 is natural and carries no special case.
- Reset asserted mid-operation returns the block to INIT and discards list contents.

Decomposition:
- Shared rename package: PREG_W, LREG_W = 5, LIST_DEPTH, INIT_BASE, and the state encoding (INIT, RUN) as localparams.
- One natural sub-module: rename_freelist_ram, a 32x6 storage with 2 write ports and 2 asynchronous read ports.
- Pointer and count logic stays in the top module.

Test Plan:
- Reset released, no requests -> oLOCK = 1 for 16 cycles. Then oINIT_DONE = 1, oFREE_COUNT = 32, oALLOC_REGNAME_0/1 = 32/33, oLOCK = 0.
- Dual requests for 16 cycles -> names 32..63 in order, oFREE_COUNT steps down by 2 to 0. oLOCK = 1 once the count is below 2, and head does not move while locked.
- Only REQ_1 in RUN -> oALLOC_REGNAME_1 = list[head] (32), head += 1, oFREE_COUNT = 31.
- At count = 0, commit OLD 5 and 7 -> the next cycle has oFREE_COUNT = 2, oLOCK = 0, offered names 5/7, and they wrap into indices 0/1.
- Allocate 6 names (32..37), commit 2 freeing 3 and 4, then restart with no commit -> head = chead = 2, oFREE_COUNT = 32. The next offers are 34/35, and 3/4 sit at indices 0/1.
- Restart plus 2 commits in the same cycle -> head = old chead + 2, oLOCK = 1 that cycle, and tail - chead stays 32.

Source files
------------

// File: rtl/rename_freelist_controller_pkg.sv
// rename_freelist_controller_pkg: shared rename parameters and free-list state encoding
package rename_freelist_controller_pkg;
  localparam int PREG_W = 6;
  localparam int LREG_W = 5;
  localparam int LIST_DEPTH = 32;
  localparam int INIT_BASE = 32;
  localparam int PTR_W = 6;
  localparam int IDX_W = 5;
  typedef enum logic {INIT = 1'b0, RUN = 1'b1} state_t;
endpackage

// File: rtl/rename_freelist_controller_if.sv
// rename_freelist_controller_if: allocate, commit and restart signals between rename stage and free list
interface rename_freelist_controller_if;
  import rename_freelist_controller_pkg::*;
  logic iRESTART_VALID;
  logic iALLOC_REQ_0;
  logic iALLOC_REQ_1;
  logic [PREG_W-1:0] oALLOC_REGNAME_0;
  logic [PREG_W-1:0] oALLOC_REGNAME_1;
  logic oLOCK;
  logic iCOMMIT_0_VALID;
  logic [PREG_W-1:0] iCOMMIT_0_OLD_REGNAME;
  logic iCOMMIT_1_VALID;
  logic [PREG_W-1:0] iCOMMIT_1_OLD_REGNAME;
  logic oINIT_DONE;
  logic [5:0] oFREE_COUNT;
  modport slave (
    input  iRESTART_VALID, iALLOC_REQ_0, iALLOC_REQ_1,
    input  iCOMMIT_0_VALID, iCOMMIT_0_OLD_REGNAME, iCOMMIT_1_VALID, iCOMMIT_1_OLD_REGNAME,
    output oALLOC_REGNAME_0, oALLOC_REGNAME_1, oLOCK, oINIT_DONE, oFREE_COUNT
  );
  modport master (
    output iRESTART_VALID, iALLOC_REQ_0, iALLOC_REQ_1,
    output iCOMMIT_0_VALID, iCOMMIT_0_OLD_REGNAME, iCOMMIT_1_VALID, iCOMMIT_1_OLD_REGNAME,
    input  oALLOC_REGNAME_0, oALLOC_REGNAME_1, oLOCK, oINIT_DONE, oFREE_COUNT
  );
endinterface

// File: rtl/rename_freelist_ram.sv
// rename_freelist_ram: 32x6 free-list storage, two write ports, two asynchronous read ports
module rename_freelist_ram
  import rename_freelist_controller_pkg::*;
(
  input  logic iCLOCK,
  input  logic we0,
  input  logic [IDX_W-1:0] wa0,
  input  logic [PREG_W-1:0] wd0,
  input  logic we1,
  input  logic [IDX_W-1:0] wa1,
  input  logic [PREG_W-1:0] wd1,
  input  logic [IDX_W-1:0] ra0,
  input  logic [IDX_W-1:0] ra1,
  output logic [PREG_W-1:0] rd0,
  output logic [PREG_W-1:0] rd1
);
  logic [PREG_W-1:0] mem [LIST_DEPTH];
  always_ff @(posedge iCLOCK) begin
    if (we0) mem[wa0] <= wd0;
    if (we1) mem[wa1] <= wd1;
  end
  assign rd0 = mem[ra0];
  assign rd1 = mem[ra1];
endmodule

// File: rtl/rename_freelist_controller.sv
// rename_freelist_controller: physical-register free list with speculative head, committed head and tail
module rename_freelist_controller
  import rename_freelist_controller_pkg::*;
(
  input  logic iCLOCK,
  input  logic inRESET,
  rename_freelist_controller_if.slave bus
);
  state_t state, state_nxt;
  logic [PTR_W-1:0] head, chead, tail, count;
  logic [3:0] init_cnt;
  logic [1:0] n, k;
  logic run, lock, r0, r1, c0, c1;
  logic we0, we1;
  logic [IDX_W-1:0] wa0, wa1, ra0, ra1;
  logic [PREG_W-1:0] wd0, wd1, rd0, rd1;
  assign r0 = bus.iALLOC_REQ_0;
  assign r1 = bus.iALLOC_REQ_1;
  assign c0 = bus.iCOMMIT_0_VALID;
  assign c1 = bus.iCOMMIT_1_VALID;
  assign run = state == RUN;
  assign count = tail - head;
  // lock ignores the request mix so the rename table never sees a loop through its requests
  assign lock = !run || count < PTR_W'(2) || bus.iRESTART_VALID;
  assign n = {1'b0, c0} + {1'b0, c1};
  assign k = lock ? 2'd0 : {1'b0, r0} + {1'b0, r1};
  assign state_nxt = (state == INIT && &init_cnt) ? RUN : state;
  always_comb begin
    we0 = run ? (c0 | c1) : 1'b1;
    we1 = run ? (c0 & c1) : 1'b1;
    wa0 = run ? tail[IDX_W-1:0] : {init_cnt, 1'b0};
    wa1 = run ? tail[IDX_W-1:0] + IDX_W'(1) : {init_cnt, 1'b1};
    wd0 = run ? (c0 ? bus.iCOMMIT_0_OLD_REGNAME : bus.iCOMMIT_1_OLD_REGNAME)
              : PREG_W'(INIT_BASE) + {1'b0, init_cnt, 1'b0};
    wd1 = run ? bus.iCOMMIT_1_OLD_REGNAME : PREG_W'(INIT_BASE) + {1'b0, init_cnt, 1'b1};
    ra0 = head[IDX_W-1:0];
    ra1 = head[IDX_W-1:0] + IDX_W'(1);
  end
  rename_freelist_ram u_ram (
    .iCLOCK(iCLOCK),
    .we0(we0), .wa0(wa0), .wd0(wd0),
    .we1(we1), .wa1(wa1), .wd1(wd1),
    .ra0(ra0), .ra1(ra1), .rd0(rd0), .rd1(rd1)
  );
  always_ff @(posedge iCLOCK or negedge inRESET)
    if (!inRESET) state <= INIT;
    else state <= state_nxt;
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      head <= '0;
      chead <= '0;
      tail <= '0;
      init_cnt <= '0;
    end else if (!run) begin
      init_cnt <= init_cnt + 4'd1;
      if (&init_cnt) tail <= PTR_W'(LIST_DEPTH);
    end else begin
      tail <= tail + PTR_W'(n);
      chead <= chead + PTR_W'(n);
      // restart rewinds to the committed point including this cycle's commits
      head <= bus.iRESTART_VALID ? chead + PTR_W'(n) : head + PTR_W'(k);
    end
  end
  always_ff @(posedge iCLOCK)
    if (inRESET && run) begin
      assert (7'(count) + 7'(n) <= 7'(LIST_DEPTH));
      assert (PTR_W'(tail - chead) == PTR_W'(LIST_DEPTH));
    end
  assign bus.oALLOC_REGNAME_0 = run ? rd0 : '0;
  assign bus.oALLOC_REGNAME_1 = run ? ((r1 && !r0) ? rd0 : rd1) : '0;
  assign bus.oLOCK = lock;
  assign bus.oINIT_DONE = run;
  assign bus.oFREE_COUNT = count;
endmodule

// File: tb/tb_rename_freelist_controller.sv
// tb_rename_freelist_controller: directed and random checks against a FIFO-queue model of the free list
module tb_rename_freelist_controller;
  logic iCLOCK = 1'b0;
  logic inRESET = 1'b0;
  rename_freelist_controller_if bus();
  rename_freelist_controller dut (.iCLOCK(iCLOCK), .inRESET(inRESET), .bus(bus.slave));
  always #5 iCLOCK = ~iCLOCK;
  int checks = 0;
  int fails = 0;
  logic [5:0] fl[$];
  int s = 0;
  int init_cnt = 0;
  bit run = 0;
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic drive(input bit r0, r1, rs, v0, v1, input logic [5:0] o0, o1);
    bus.iALLOC_REQ_0 = r0;
    bus.iALLOC_REQ_1 = r1;
    bus.iRESTART_VALID = rs;
    bus.iCOMMIT_0_VALID = v0;
    bus.iCOMMIT_1_VALID = v1;
    bus.iCOMMIT_0_OLD_REGNAME = o0;
    bus.iCOMMIT_1_OLD_REGNAME = o1;
  endtask
  task automatic do_reset();
    @(negedge iCLOCK);
    inRESET = 1'b0;
    drive(0, 0, 0, 0, 0, 6'd0, 6'd0);
    #1;
    chk("rst_lock", 8'(bus.oLOCK), 8'd1);
    chk("rst_done", 8'(bus.oINIT_DONE), 8'd0);
    chk("rst_count", 8'(bus.oFREE_COUNT), 8'd0);
    chk("rst_name0", 8'(bus.oALLOC_REGNAME_0), 8'd0);
    chk("rst_name1", 8'(bus.oALLOC_REGNAME_1), 8'd0);
    @(negedge iCLOCK);
    inRESET = 1'b1;
    run = 0;
    init_cnt = 0;
    s = 0;
    fl.delete();
  endtask
  task automatic step(input bit r0, r1, rs, v0, v1, input logic [5:0] o0, o1);
    bit lk;
    int k, n;
    drive(r0, r1, rs, v0, v1, o0, o1);
    #1;
    lk = !run || (32 - s) < 2 || rs;
    chk("lock", 8'(bus.oLOCK), 8'(lk));
    chk("init_done", 8'(bus.oINIT_DONE), 8'(run));
    chk("count", 8'(bus.oFREE_COUNT), run ? 8'(32 - s) : 8'd0);
    if (!run) begin
      chk("init_name0", 8'(bus.oALLOC_REGNAME_0), 8'd0);
      chk("init_name1", 8'(bus.oALLOC_REGNAME_1), 8'd0);
    end else if (!lk) begin
      if (r0 || !r1) chk("name0", 8'(bus.oALLOC_REGNAME_0), 8'(fl[s]));
      if (r1 && !r0) chk("name1_single", 8'(bus.oALLOC_REGNAME_1), 8'(fl[s]));
      else chk("name1", 8'(bus.oALLOC_REGNAME_1), 8'(fl[s+1]));
    end
    if (!run) begin
      init_cnt++;
      if (init_cnt == 16) begin
        run = 1;
        for (int i = 0; i < 32; i++) fl.push_back(6'(32 + i));
        s = 0;
      end
    end else begin
      k = lk ? 0 : int'(r0) + int'(r1);
      n = int'(v0) + int'(v1);
      repeat (n) void'(fl.pop_front());
      if (v0) fl.push_back(o0);
      if (v1) fl.push_back(o1);
      s = rs ? 0 : s - n + k;
    end
    @(negedge iCLOCK);
  endtask
  task automatic rand_step();
    bit r0, r1, rs, v0, v1;
    int mx, n;
    r0 = 1'($urandom_range(0, 1));
    r1 = 1'($urandom_range(0, 1));
    rs = $urandom_range(0, 11) == 0;
    mx = run ? (s < 2 ? s : 2) : 0;
    n = $urandom_range(0, mx);
    v0 = n == 2 || (n == 1 && $urandom_range(0, 1) == 1);
    v1 = n == 2 || (n == 1 && !v0);
    step(r0, r1, rs, v0, v1, 6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)));
  endtask
  initial begin
    do_reset();
    repeat (17) step(0, 0, 0, 0, 0, 6'd0, 6'd0);
    repeat (18) step(1, 1, 0, 0, 0, 6'd0, 6'd0);
    step(0, 0, 0, 1, 1, 6'd5, 6'd7);
    step(1, 1, 0, 0, 0, 6'd0, 6'd0);
    step(0, 0, 0, 0, 0, 6'd0, 6'd0);
    do_reset();
    repeat (16) step(0, 0, 0, 0, 0, 6'd0, 6'd0);
    step(0, 1, 0, 0, 0, 6'd0, 6'd0);
    step(0, 0, 0, 0, 0, 6'd0, 6'd0);
    do_reset();
    repeat (16) step(0, 0, 0, 0, 0, 6'd0, 6'd0);
    repeat (3) step(1, 1, 0, 0, 0, 6'd0, 6'd0);
    step(0, 0, 0, 1, 1, 6'd3, 6'd4);
    step(0, 0, 1, 0, 0, 6'd0, 6'd0);
    step(1, 1, 0, 0, 0, 6'd0, 6'd0);
    step(1, 1, 1, 1, 1, 6'd9, 6'd10);
    step(0, 0, 0, 0, 0, 6'd0, 6'd0);
    for (int i = 0; i < 600; i++) begin
      if (i == 300) do_reset();
      rand_step();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
